icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 28 ++
 rtl/icache.sv | 106 ++++++++++
 tb/tb_icache.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, plus its
// performance counters, bundled so the cache and its environment share one port.
interface icache_if;
    // Fetch: iren asks for iaddr; the word is valid in the same cycle only when ihit=1.
    // Memory: ramREN holds ramaddr steady until a cycle with iwait=0, and ramload is
    // valid in that cycle. Both sides see a transfer only in cycles where both agree.
    logic        iren;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        inval;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic        iwait;
    logic [31:0] ramload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  iren, iaddr, inval, iwait, ramload,
        output ihit, imemload, ramREN, ramaddr, hit_count, miss_count
    );

    modport master (
        output iren, iaddr, inval, iwait, ramload,
        input  ihit, imemload, ramREN, ramaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames held in flops.
// Misses block in FILL until memory answers; the refilled word is hit on the next cycle.
module icache #(
    parameter int SETS = 16
) (
    input  logic     CLK,
    input  logic     RST,
    icache_if.slave  bus,
    output logic     dbg_state
);
    localparam int IB = $clog2(SETS);
    localparam int TW = 30 - IB;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t          state, state_n;
    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags [SETS];
    logic [31:0]     data [SETS];
    logic [31:0]     miss_addr;
    logic [31:0]     hit_q, miss_q;

    logic [IB-1:0]   idx, fill_idx;
    logic [TW-1:0]   tag, fill_tag;
    logic            lookup_hit;
    logic            hit_evt, miss_evt, fill_done;
    logic            unused_low_bits;

    assign idx      = bus.iaddr[2+IB-1:2];
    assign tag      = bus.iaddr[31:2+IB];
    assign fill_idx = miss_addr[2+IB-1:2];
    assign fill_tag = miss_addr[31:2+IB];
    assign unused_low_bits = ^bus.iaddr[1:0];

    assign lookup_hit = valid[idx] && (tags[idx] == tag);

    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
    assign dbg_state      = (state == FILL);

    always_comb begin
        state_n      = state;
        hit_evt      = 1'b0;
        miss_evt     = 1'b0;
        fill_done    = 1'b0;
        bus.ihit     = 1'b0;
        bus.imemload = 32'h0;
        bus.ramREN   = 1'b0;
        bus.ramaddr  = 32'h0;
        case (state)
            IDLE: begin
                // An invalidate cycle neither hits nor starts a fill.
                if (bus.iren && !bus.inval) begin
                    if (lookup_hit) begin
                        bus.ihit     = 1'b1;
                        bus.imemload = data[idx];
                        hit_evt      = 1'b1;
                    end else begin
                        miss_evt = 1'b1;
                        state_n  = FILL;
                    end
                end
            end
            FILL: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = miss_addr;
                if (!bus.iwait) begin
                    fill_done = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= 32'h0;
            hit_q     <= 32'h0;
            miss_q    <= 32'h0;
        end else begin
            state <= state_n;
            if (miss_evt)
                miss_addr <= bus.iaddr;
            if (bus.inval)
                valid <= '0;
            // Placed after the clear so a fill finishing under inval keeps its frame.
            if (fill_done)
                valid[fill_idx] <= 1'b1;
            if (hit_evt && hit_q != 32'hFFFF_FFFF)
                hit_q <= hit_q + 32'd1;
            if (miss_evt && miss_q != 32'hFFFF_FFFF)
                miss_q <= miss_q + 32'd1;
        end
    end

    // Tag and data need no reset: valid bits gate every hit.
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= bus.ramload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: each scenario task drives the fetch and memory sides
// at the falling edge and checks outputs 1ns later.
`timescale 1ns/1ps
module tb_icache;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic dbg_state;
  int n_checks = 0;
  int n_bad = 0;

  icache_if bus();

  icache #(.SETS(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // ---------------- driver tasks ----------------
  task automatic req(input logic [31:0] addr, input logic en);
    @(negedge CLK);
    bus.iren = en;
    bus.iaddr = addr;
    bus.iwait = 1'b1;
    bus.inval = 1'b0;
    bus.ramload = 32'h0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.iren = 1'b0;
    bus.iaddr = 32'h0;
    bus.inval = 1'b0;
    bus.iwait = 1'b1;
    bus.ramload = 32'h0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Request a missing word; memory holds iwait for 'waits' FILL cycles, then answers.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] word, input int waits,
                         input bit drop, input int inval_at,
                         output int ren_cycles, output logic req_hit,
                         output logic [31:0] first_ramaddr, output bit leak);
    ren_cycles = 0;
    leak = 1'b0;
    first_ramaddr = 32'h0;
    @(negedge CLK);
    bus.iren = 1'b1;
    bus.iaddr = addr;
    bus.iwait = 1'b1;
    bus.inval = 1'b0;
    bus.ramload = 32'h0;
    #1;
    req_hit = bus.ihit;
    for (int k = 0; k <= waits; k++) begin
      @(negedge CLK);
      bus.iwait = (k < waits);
      bus.ramload = (k == waits) ? word : 32'hDEAD_BEEF;
      bus.inval = (k == inval_at);
      if (drop) begin
        bus.iren = 1'b0;
        bus.iaddr = 32'h0000_0ABC;
      end
      #1;
      if (bus.ramREN === 1'b1) ren_cycles++;
      if (k == 0) first_ramaddr = bus.ramaddr;
      if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) leak = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.iren = 1'b1;
    bus.iaddr = 32'h40;
    bus.inval = 1'b0;
    bus.iwait = 1'b1;
    bus.ramload = 32'h1234_5678;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out ihit=%0b imemload=%h exp 0/0", bus.ihit, bus.imemload);
    end
    n_checks++;
    if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ram ramREN=%0b ramaddr=%h exp 0/0", bus.ramREN, bus.ramaddr);
    end
    n_checks++;
    if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0 || dbg_state !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cnt hit=%0d miss=%0d state=%0b exp 0/0/0", bus.hit_count, bus.miss_count, dbg_state);
    end
    bus.iren = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_cold_miss();
    int ren;
    logic rh;
    logic [31:0] ra;
    bit leak;
    do_reset();
    do_miss(32'h0000_0040, 32'h2401_0005, 3, 1'b0, -1, ren, rh, ra, leak);
    n_checks++;
    if (rh !== 1'b0 || ren != 4 || ra !== 32'h40) begin
      n_bad++;
      $display("FAIL cold_fill req_hit=%0b ren_cycles=%0d ramaddr=%h exp 0/4/00000040", rh, ren, ra);
    end
    n_checks++;
    if (leak) begin
      n_bad++;
      $display("FAIL cold_leak ihit/imemload nonzero during FILL exp zero");
    end
    req(32'h0000_0040, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2401_0005 || bus.ramREN !== 1'b0) begin
      n_bad++;
      $display("FAIL cold_hit ihit=%0b data=%h ramREN=%0b exp 1/24010005/0", bus.ihit, bus.imemload, bus.ramREN);
    end
    req(32'h0000_0043, 1'b1);
    n_checks++;
    if (bus.hit_count !== 32'd1 || bus.miss_count !== 32'd1) begin
      n_bad++;
      $display("FAIL cold_cnt hit=%0d miss=%0d exp 1/1", bus.hit_count, bus.miss_count);
    end
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2401_0005) begin
      n_bad++;
      $display("FAIL low_bits ihit=%0b data=%h exp 1/24010005", bus.ihit, bus.imemload);
    end
    req(32'h0000_0040, 1'b0);
    n_checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0 || bus.ramREN !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_out ihit=%0b data=%h ramREN=%0b exp 0/0/0", bus.ihit, bus.imemload, bus.ramREN);
    end
  endtask

  task automatic test_conflict();
    int ren;
    logic rh;
    logic [31:0] ra;
    bit leak;
    do_reset();
    do_miss(32'h0, 32'h1111_0000, 1, 1'b0, -1, ren, rh, ra, leak);
    req(32'h0, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1111_0000) begin
      n_bad++;
      $display("FAIL conf_first ihit=%0b data=%h exp 1/11110000", bus.ihit, bus.imemload);
    end
    do_miss(32'h40, 32'h2222_0040, 0, 1'b0, -1, ren, rh, ra, leak);
    req(32'h40, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2222_0040) begin
      n_bad++;
      $display("FAIL conf_second ihit=%0b data=%h exp 1/22220040", bus.ihit, bus.imemload);
    end
    do_miss(32'h0, 32'h3333_0000, 2, 1'b0, -1, ren, rh, ra, leak);
    n_checks++;
    if (rh !== 1'b0 || ren != 3 || ra !== 32'h0) begin
      n_bad++;
      $display("FAIL conf_evict req_hit=%0b ren_cycles=%0d ramaddr=%h exp 0/3/00000000", rh, ren, ra);
    end
    req(32'h0, 1'b1);
    n_checks++;
    if (bus.miss_count !== 32'd3 || bus.hit_count !== 32'd2 || bus.imemload !== 32'h3333_0000) begin
      n_bad++;
      $display("FAIL conf_cnt miss=%0d hit=%0d data=%h exp 3/2/33330000", bus.miss_count, bus.hit_count, bus.imemload);
    end
  endtask

  task automatic test_abandon();
    int ren;
    logic rh;
    logic [31:0] ra;
    bit leak;
    do_reset();
    do_miss(32'h100, 32'h5555_0100, 2, 1'b1, -1, ren, rh, ra, leak);
    n_checks++;
    if (ren != 3 || ra !== 32'h100) begin
      n_bad++;
      $display("FAIL aband_fill ren_cycles=%0d ramaddr=%h exp 3/00000100", ren, ra);
    end
    req(32'h100, 1'b0);
    req(32'h100, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'h5555_0100 || bus.ramREN !== 1'b0) begin
      n_bad++;
      $display("FAIL aband_hit ihit=%0b data=%h ramREN=%0b exp 1/55550100/0", bus.ihit, bus.imemload, bus.ramREN);
    end
    req(32'h0, 1'b0);
    n_checks++;
    if (bus.miss_count !== 32'd1 || bus.hit_count !== 32'd1) begin
      n_bad++;
      $display("FAIL aband_cnt miss=%0d hit=%0d exp 1/1", bus.miss_count, bus.hit_count);
    end
  endtask

  task automatic test_invalidate();
    int ren;
    logic rh;
    logic [31:0] ra;
    bit leak;
    do_reset();
    do_miss(32'h8, 32'hAAAA_0008, 1, 1'b0, -1, ren, rh, ra, leak);
    req(32'h8, 1'b1);
    @(negedge CLK);
    bus.inval = 1'b1;
    #1;
    n_checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
      n_bad++;
      $display("FAIL inval_idle ihit=%0b data=%h exp 0/0", bus.ihit, bus.imemload);
    end
    do_miss(32'h8, 32'hBBBB_0008, 0, 1'b0, -1, ren, rh, ra, leak);
    n_checks++;
    if (rh !== 1'b0 || ren != 1) begin
      n_bad++;
      $display("FAIL inval_remiss req_hit=%0b ren_cycles=%0d exp 0/1", rh, ren);
    end
    req(32'h8, 1'b1);
    n_checks++;
    if (bus.miss_count !== 32'd2 || bus.hit_count !== 32'd1 || bus.imemload !== 32'hBBBB_0008) begin
      n_bad++;
      $display("FAIL inval_cnt miss=%0d hit=%0d data=%h exp 2/1/BBBB0008", bus.miss_count, bus.hit_count, bus.imemload);
    end
    do_miss(32'hC, 32'hCCCC_000C, 2, 1'b0, 1, ren, rh, ra, leak);
    req(32'hC, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.imemload !== 32'hCCCC_000C) begin
      n_bad++;
      $display("FAIL inval_fill ihit=%0b data=%h exp 1/CCCC000C", bus.ihit, bus.imemload);
    end
    req(32'h8, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b0 || bus.miss_count !== 32'd3 || bus.hit_count !== 32'd3) begin
      n_bad++;
      $display("FAIL inval_other ihit=%0b miss=%0d hit=%0d exp 0/3/3", bus.ihit, bus.miss_count, bus.hit_count);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    req(32'h200, 1'b1);
    @(negedge CLK);
    #1;
    n_checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200) begin
      n_bad++;
      $display("FAIL rmid_fill ramREN=%0b ramaddr=%h exp 1/00000200", bus.ramREN, bus.ramaddr);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_checks++;
    if (bus.ramREN !== 1'b0 || bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0 || bus.ihit !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_drop ramREN=%0b hit=%0d miss=%0d ihit=%0b exp 0/0/0/0", bus.ramREN, bus.hit_count, bus.miss_count, bus.ihit);
    end
    @(negedge CLK);
    #1;
    n_checks++;
    if (bus.ramREN !== 1'b1 || bus.miss_count !== 32'd1) begin
      n_bad++;
      $display("FAIL rmid_remiss ramREN=%0b miss=%0d exp 1/1", bus.ramREN, bus.miss_count);
    end
    do_reset();
  endtask

  task automatic test_back_to_back_saturate();
    int ren;
    logic rh;
    logic [31:0] ra;
    bit leak;
    do_reset();
    do_miss(32'h10, 32'h7777_0010, 0, 1'b0, -1, ren, rh, ra, leak);
    req(32'h10, 1'b0);
    force dut.hit_q = 32'hFFFF_FFFE;
    req(32'h10, 1'b0);
    release dut.hit_q;
    req(32'h10, 1'b1);
    n_checks++;
    if (bus.ihit !== 1'b1 || bus.hit_count !== 32'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL sat_pre ihit=%0b hit=%h exp 1/FFFFFFFE", bus.ihit, bus.hit_count);
    end
    req(32'h10, 1'b1);
    req(32'h10, 1'b0);
    n_checks++;
    if (bus.hit_count !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL sat_top hit=%h exp FFFFFFFF", bus.hit_count);
    end
    req(32'h10, 1'b1);
    req(32'h0, 1'b0);
    n_checks++;
    if (bus.hit_count !== 32'hFFFF_FFFF || bus.miss_count !== 32'd1) begin
      n_bad++;
      $display("FAIL sat_hold hit=%h miss=%0d exp FFFFFFFF/1", bus.hit_count, bus.miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_abandon();
    test_invalidate();
    test_reset_mid_fill();
    test_back_to_back_saturate();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
